// File: rtl/exe_mem_stage.sv
// exe_mem_stage: execute / memory pipeline stage.
// Accepts one decoded instruction per cycle while idle. ALU, branch and jump
// results appear one cycle after acceptance. Loads and stores hold a memory
// request open until mem_ack, and no new instruction is accepted meanwhile.
module exe_mem_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,        // asynchronous, active-low
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      optype,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [RA_W-1:0] rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            out_valid,
    output logic            out_we,
    output logic [RA_W-1:0] out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            jmp_en,
    output logic [XLEN-1:0] jmp_addr,
    output logic            flush
);

    localparam int SH_W = $clog2(XLEN);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_SLL   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_ADDI  = 5'd10;
    localparam logic [4:0] OP_LOAD  = 5'd11;
    localparam logic [4:0] OP_STORE = 5'd12;
    localparam logic [4:0] OP_BEQ   = 5'd13;
    localparam logic [4:0] OP_BNE   = 5'd14;
    localparam logic [4:0] OP_JAL   = 5'd15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MEM  = 1'b1
    } state_t;

    state_t state_reg, state_next;

    // Registered outputs and their next-state values
    logic            mem_req_reg,   mem_req_next;
    logic            mem_we_reg,    mem_we_next;
    logic [XLEN-1:0] mem_addr_reg,  mem_addr_next;
    logic [XLEN-1:0] mem_wdata_reg, mem_wdata_next;
    logic            out_valid_reg, out_valid_next;
    logic            out_we_reg,    out_we_next;
    logic [RA_W-1:0] out_rd_reg,    out_rd_next;
    logic [XLEN-1:0] out_data_reg,  out_data_next;
    logic            jmp_en_reg,    jmp_en_next;
    logic [XLEN-1:0] jmp_addr_reg,  jmp_addr_next;
    logic            flush_reg,     flush_next;

    // Bookkeeping for the outstanding memory operation
    logic            pend_load_reg, pend_load_next;
    logic [RA_W-1:0] pend_rd_reg,   pend_rd_next;

    logic            accept;
    logic [XLEN-1:0] alu_result;
    logic [SH_W-1:0] shamt;
    logic            lt_signed;
    logic            lt_unsigned;
    logic [XLEN-1:0] target_addr;
    logic [XLEN-1:0] eff_addr;
    logic [XLEN-1:0] link_addr;

    assign in_ready    = (state_reg == ST_IDLE);
    assign accept      = in_valid & in_ready;
    assign shamt       = rs2_data[SH_W-1:0];
    assign lt_signed   = $signed(rs1_data) < $signed(rs2_data);
    assign lt_unsigned = rs1_data < rs2_data;
    assign target_addr = pc + imm;
    assign eff_addr    = rs1_data + imm;
    assign link_addr   = pc + XLEN'(4);

    // ALU datapath for opcodes 0..10; unused opcodes yield zero
    always_comb begin
        alu_result = '0;
        case (optype)
            OP_ADD:  alu_result = rs1_data + rs2_data;
            OP_SUB:  alu_result = rs1_data - rs2_data;
            OP_AND:  alu_result = rs1_data & rs2_data;
            OP_OR:   alu_result = rs1_data | rs2_data;
            OP_XOR:  alu_result = rs1_data ^ rs2_data;
            OP_SLL:  alu_result = rs1_data << shamt;
            OP_SRL:  alu_result = rs1_data >> shamt;
            OP_SRA:  alu_result = $unsigned($signed(rs1_data) >>> shamt);
            OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, lt_signed};
            OP_SLTU: alu_result = {{(XLEN-1){1'b0}}, lt_unsigned};
            OP_ADDI: alu_result = rs1_data + imm;
            default: alu_result = '0;
        endcase
    end

    // Next-state and output logic: pulses default low, data outputs hold
    always_comb begin
        state_next     = state_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        out_valid_next = 1'b0;
        out_we_next    = 1'b0;
        out_rd_next    = out_rd_reg;
        out_data_next  = out_data_reg;
        jmp_en_next    = 1'b0;
        flush_next     = 1'b0;
        jmp_addr_next  = jmp_addr_reg;
        pend_load_next = pend_load_reg;
        pend_rd_next   = pend_rd_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (optype)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL,
                        OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_ADDI: begin
                            out_valid_next = 1'b1;
                            out_we_next    = (rd != '0);
                            out_rd_next    = rd;
                            out_data_next  = alu_result;
                        end
                        OP_LOAD, OP_STORE: begin
                            state_next     = ST_MEM;
                            mem_req_next   = 1'b1;
                            mem_we_next    = (optype == OP_STORE);
                            mem_addr_next  = eff_addr;
                            if (optype == OP_STORE) begin
                                mem_wdata_next = rs2_data;
                            end
                            pend_load_next = (optype == OP_LOAD);
                            pend_rd_next   = rd;
                        end
                        OP_BEQ, OP_BNE: begin
                            // Only a taken branch redirects fetch
                            if ((rs1_data == rs2_data) == (optype == OP_BEQ)) begin
                                jmp_en_next   = 1'b1;
                                flush_next    = 1'b1;
                                jmp_addr_next = target_addr;
                            end
                        end
                        OP_JAL: begin
                            jmp_en_next    = 1'b1;
                            flush_next     = 1'b1;
                            jmp_addr_next  = target_addr;
                            out_valid_next = 1'b1;
                            out_we_next    = (rd != '0);
                            out_rd_next    = rd;
                            out_data_next  = link_addr;
                        end
                        default: begin
                            // NOP: consumed without any visible effect
                        end
                    endcase
                end
            end
            ST_MEM: begin
                // Request stays frozen until the ack is sampled
                if (mem_ack) begin
                    state_next     = ST_IDLE;
                    mem_req_next   = 1'b0;
                    mem_we_next    = 1'b0;
                    pend_load_next = 1'b0;
                    if (pend_load_reg) begin
                        out_valid_next = 1'b1;
                        out_we_next    = (pend_rd_reg != '0);
                        out_rd_next    = pend_rd_reg;
                        out_data_next  = mem_rdata;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register; reset abandons any outstanding memory request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output and pending-operation registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            out_valid_reg <= 1'b0;
            out_we_reg    <= 1'b0;
            out_rd_reg    <= '0;
            out_data_reg  <= '0;
            jmp_en_reg    <= 1'b0;
            jmp_addr_reg  <= '0;
            flush_reg     <= 1'b0;
            pend_load_reg <= 1'b0;
            pend_rd_reg   <= '0;
        end else begin
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            out_valid_reg <= out_valid_next;
            out_we_reg    <= out_we_next;
            out_rd_reg    <= out_rd_next;
            out_data_reg  <= out_data_next;
            jmp_en_reg    <= jmp_en_next;
            jmp_addr_reg  <= jmp_addr_next;
            flush_reg     <= flush_next;
            pend_load_reg <= pend_load_next;
            pend_rd_reg   <= pend_rd_next;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign out_valid = out_valid_reg;
    assign out_we    = out_we_reg;
    assign out_rd    = out_rd_reg;
    assign out_data  = out_data_reg;
    assign jmp_en    = jmp_en_reg;
    assign jmp_addr  = jmp_addr_reg;
    assign flush     = flush_reg;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed testbench for exe_mem_stage with hand-computed expectations.
module tb_exe_mem_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  optype;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic        out_we;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        jmp_en;
    logic [31:0] jmp_addr;
    logic        flush;

    int n_tests = 0;
    int n_fail  = 0;

    exe_mem_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .optype    (optype),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .imm       (imm),
        .pc        (pc),
        .rd        (rd),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .out_valid (out_valid),
        .out_we    (out_we),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .jmp_en    (jmp_en),
        .jmp_addr  (jmp_addr),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p, input logic [4:0] r);
        in_valid = 1'b1;
        optype   = op;
        rs1_data = a;
        rs2_data = b;
        imm      = im;
        pc       = p;
        rd       = r;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        optype   = 5'd31;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; optype = 5'd0; rs1_data = '0; rs2_data = '0;
        imm = '0; pc = '0; rd = '0; mem_rdata = '0; mem_ack = 1'b0;

        // Reset state
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_jmp_en", 32'(jmp_en), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_jmp_addr", jmp_addr, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        rst = 1'b1;

        // ADD wraps modulo 2^32
        drive(5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
        step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_we", 32'(out_we), 32'd1);
        chk("add_rd", 32'(out_rd), 32'd3);
        chk("add_data", out_data, 32'd0);
        $display("[TB] ADD  data=0x%08h", out_data);

        // Back-to-back ALU ops
        drive(5'd7, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 5'd4);
        step();
        chk("sra_valid", 32'(out_valid), 32'd1);
        chk("sra_data", out_data, 32'hF800_0000);
        $display("[TB] SRA  data=0x%08h", out_data);
        drive(5'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd6);
        step();
        chk("slt_data", out_data, 32'd1);
        chk("slt_rd", 32'(out_rd), 32'd6);
        $display("[TB] SLT  data=0x%08h", out_data);
        drive(5'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd6);
        step();
        chk("sltu_data", out_data, 32'd0);
        $display("[TB] SLTU data=0x%08h", out_data);
        drive(5'd1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd7);
        step();
        chk("sub_data", out_data, 32'hFFFF_FFFE);
        $display("[TB] SUB  data=0x%08h", out_data);
        drive(5'd5, 32'd1, 32'h3F, 32'd0, 32'd0, 5'd8);
        step();
        chk("sll_data", out_data, 32'h8000_0000);
        $display("[TB] SLL  data=0x%08h", out_data);
        drive(5'd6, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd8);
        step();
        chk("srl_data", out_data, 32'h0800_0000);
        $display("[TB] SRL  data=0x%08h", out_data);
        drive(5'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd9);
        step();
        chk("xor_data", out_data, 32'h0FF0_0FF0);
        $display("[TB] XOR  data=0x%08h", out_data);
        drive(5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0, 5'd9);
        step();
        chk("and_data", out_data, 32'hF000_F000);
        $display("[TB] AND  data=0x%08h", out_data);
        drive(5'd3, 32'hF0F0_F0F0, 32'h0F00_0F00, 32'd0, 32'd0, 5'd9);
        step();
        chk("or_data", out_data, 32'hFFF0_FFF0);
        $display("[TB] OR   data=0x%08h", out_data);
        drive(5'd10, 32'd100, 32'd999, 32'hFFFF_FFFC, 32'd0, 5'd10);
        step();
        chk("addi_data", out_data, 32'd96);
        $display("[TB] ADDI data=0x%08h", out_data);
        // rd == 0: still pulses valid, no write enable
        drive(5'd0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd0);
        step();
        chk("rd0_valid", 32'(out_valid), 32'd1);
        chk("rd0_we", 32'(out_we), 32'd0);
        chk("rd0_data", out_data, 32'd3);
        $display("[TB] ADD rd0 we=%0d", out_we);
        idle_in();
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_hold_data", out_data, 32'd3);

        // Branches
        drive(5'd13, 32'd7, 32'd7, 32'hFFFF_FFF8, 32'h40, 5'd2);
        step();
        chk("beq_jmp_en", 32'(jmp_en), 32'd1);
        chk("beq_flush", 32'(flush), 32'd1);
        chk("beq_jmp_addr", jmp_addr, 32'h38);
        chk("beq_no_wb", 32'(out_valid), 32'd0);
        $display("[TB] BEQ  jmp_en=%0d addr=0x%08h", jmp_en, jmp_addr);
        drive(5'd14, 32'd7, 32'd7, 32'hFFFF_FFF8, 32'h40, 5'd2);
        step();
        chk("bne_jmp_en", 32'(jmp_en), 32'd0);
        chk("bne_flush", 32'(flush), 32'd0);
        $display("[TB] BNE  jmp_en=%0d", jmp_en);

        // JAL
        drive(5'd15, 32'd0, 32'd0, 32'h10, 32'h200, 5'd1);
        step();
        chk("jal_jmp_en", 32'(jmp_en), 32'd1);
        chk("jal_jmp_addr", jmp_addr, 32'h210);
        chk("jal_data", out_data, 32'h204);
        chk("jal_we", 32'(out_we), 32'd1);
        chk("jal_valid", 32'(out_valid), 32'd1);
        $display("[TB] JAL  addr=0x%08h link=0x%08h", jmp_addr, out_data);
        drive(5'd15, 32'd0, 32'd0, 32'h10, 32'h200, 5'd0);
        step();
        chk("jal_rd0_we", 32'(out_we), 32'd0);
        chk("jal_rd0_valid", 32'(out_valid), 32'd1);
        $display("[TB] JAL rd0 we=%0d", out_we);

        // NOP
        drive(5'd20, 32'd1, 32'd1, 32'd1, 32'd1, 5'd1);
        step();
        chk("nop_valid", 32'(out_valid), 32'd0);
        chk("nop_jmp", 32'(jmp_en), 32'd0);
        chk("nop_req", 32'(mem_req), 32'd0);
        $display("[TB] NOP  valid=%0d", out_valid);

        // LOAD with ack in the third MEM cycle; an ADD waits in the slot meanwhile
        drive(5'd11, 32'h100, 32'd0, 32'd4, 32'd0, 5'd5);
        step();
        drive(5'd0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd9);
        for (int c = 1; c <= 3; c++) begin
            chk("ld_req", 32'(mem_req), 32'd1);
            chk("ld_we", 32'(mem_we), 32'd0);
            chk("ld_addr", mem_addr, 32'h104);
            chk("ld_ready", 32'(in_ready), 32'd0);
            chk("ld_no_wb", 32'(out_valid), 32'd0);
            $display("[TB] LOAD mem cycle %0d addr=0x%08h", c, mem_addr);
            if (c == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                idle_in();
            end
            step();
        end
        mem_ack = 1'b0;
        mem_rdata = '0;
        chk("ld_req_drop", 32'(mem_req), 32'd0);
        chk("ld_valid", 32'(out_valid), 32'd1);
        chk("ld_data", out_data, 32'hDEAD_BEEF);
        chk("ld_rd", 32'(out_rd), 32'd5);
        chk("ld_wb_we", 32'(out_we), 32'd1);
        chk("ld_ready_back", 32'(in_ready), 32'd1);
        $display("[TB] LOAD data=0x%08h rd=%0d", out_data, out_rd);
        step();
        chk("ld_pulse_end", 32'(out_valid), 32'd0);

        // STORE with immediate ack
        drive(5'd12, 32'h20, 32'h0000_CAFE, 32'h8, 32'd0, 5'd0);
        step();
        idle_in();
        chk("st_req", 32'(mem_req), 32'd1);
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_addr", mem_addr, 32'h28);
        chk("st_wdata", mem_wdata, 32'h0000_CAFE);
        chk("st_ready", 32'(in_ready), 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("st_req_drop", 32'(mem_req), 32'd0);
        chk("st_no_wb", 32'(out_valid), 32'd0);
        chk("st_ready_back", 32'(in_ready), 32'd1);
        $display("[TB] STORE addr=0x%08h wdata=0x%08h", mem_addr, mem_wdata);

        // Stray ack while idle is ignored
        mem_ack = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_ack = 1'b0;
        chk("stray_ack_valid", 32'(out_valid), 32'd0);
        chk("stray_ack_data", out_data, 32'hDEAD_BEEF);

        // STORE abandoned by reset mid-MEM, late ack after release
        drive(5'd12, 32'h40, 32'h55, 32'h4, 32'd0, 5'd0);
        step();
        idle_in();
        chk("rs_req", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rs_req_async", 32'(mem_req), 32'd0);
        chk("rs_we_async", 32'(mem_we), 32'd0);
        chk("rs_ready", 32'(in_ready), 32'd1);
        chk("rs_out_data", out_data, 32'd0);
        chk("rs_mem_addr", mem_addr, 32'd0);
        step();
        rst = 1'b1;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("rs_late_ack_valid", 32'(out_valid), 32'd0);
        chk("rs_late_ack_req", 32'(mem_req), 32'd0);
        chk("rs_late_ready", 32'(in_ready), 32'd1);
        $display("[TB] RESET mid-MEM req=%0d ready=%0d", mem_req, in_ready);

        // Stage still works after recovery
        drive(5'd0, 32'd10, 32'd20, 32'd0, 32'd0, 5'd12);
        step();
        idle_in();
        chk("post_rst_data", out_data, 32'd30);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        $display("[TB] ADD after reset data=0x%08h", out_data);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_mem_stage.md
EXE_MEM_STAGE -- requirements
Module: exe_mem_stage

Interface
REQ-001 Parameter XLEN, default 32, operand/result/address width.
REQ-002 Parameter RA_W, default 5, register-address width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  issue slot holds a valid instruction.
REQ-006 in_ready  output  1  stage accepts an instruction this cycle.
REQ-007 optype  input  5  operation code per REQ-014.
REQ-008 rs1_data, rs2_data  input  XLEN  source operands.
REQ-009 imm, pc  input  XLEN  sign-extended immediate; instruction address.
REQ-010 rd  input  RA_W  destination register address.
REQ-011 mem_req, mem_we  output  1  memory request; 1 = store.
REQ-012 mem_addr, mem_wdata  output  XLEN  request address; store data. mem_rdata input XLEN load data; mem_ack input 1 completes request.
REQ-013 out_valid output 1, out_we output 1, out_rd output RA_W, out_data output XLEN: writeback. jmp_en output 1, jmp_addr output XLEN, flush output 1.

Function
REQ-014 Encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 ADDI, 11 LOAD, 12 STORE, 13 BEQ, 14 BNE, 15 JAL; 16-31 NOP.
REQ-015 FSM states IDLE, MEM; in_ready = 1 only in IDLE.
REQ-016 Accept = in_valid & in_ready; without accept, no output changes except those below.
REQ-017 ALU ops (0-10): out_valid=1, out_we=1, out_rd=rd, out_data=result for exactly one cycle, the cycle after accept.
REQ-018 Arithmetic modulo 2^XLEN; shifts use rs2_data[log2(XLEN)-1:0]; SLT signed, SLTU unsigned, result 0/1 zero-extended.
REQ-019 out_we=0 whenever rd==0; out_valid still pulses.
REQ-020 LOAD/STORE: next cycle enter MEM; mem_addr=rs1_data+imm, mem_wdata=rs2_data (STORE), mem_we per op, mem_req=1.
REQ-021 In MEM, mem_req, mem_we, mem_addr, mem_wdata held stable until the cycle mem_ack=1 is sampled; then mem_req=0 and return to IDLE next cycle.
REQ-022 LOAD: cycle after ack, out_valid=1, out_we=(rd!=0), out_data=mem_rdata captured at ack.
REQ-023 STORE: no out_valid pulse.
REQ-024 mem_ack outside MEM ignored; ack in the same cycle mem_req first asserts is valid (minimum 1 MEM cycle).
REQ-025 BEQ/BNE: cycle after accept, jmp_en=flush=1 for one cycle if condition true, jmp_addr=pc+imm; no writeback.
REQ-026 JAL: cycle after accept, jmp_en=flush=1, jmp_addr=pc+imm, writeback out_data=pc+4 per REQ-017/019.
REQ-027 NOP: accepted, no outputs asserted.
REQ-028 Back-to-back ALU/branch ops accepted every cycle; a memory op blocks issue until return to IDLE.
REQ-029 in_ready stays 0 from the cycle after a memory op is accepted until IDLE; it is 0 in that acceptance cycle's successor even if ack is immediate.

Reset
REQ-030 rst low asynchronously forces IDLE; in_ready=1 after release; mem_req, mem_we, out_valid, out_we, jmp_en, flush = 0; mem_addr, mem_wdata, out_data, jmp_addr, out_rd = 0.
REQ-031 rst low during MEM abandons the request; pending load result discarded; a late mem_ack after release ignored.
REQ-032 No input sampled while rst low.

Verification
REQ-033 ADD rs1=0xFFFFFFFF, rs2=1, rd=3 -> next cycle out_valid=1, out_we=1, out_rd=3, out_data=0.
REQ-034 SRA rs1=0x80000000, rs2=0x24 -> out_data=0xF8000000 (shift 4); SLT rs1=-1, rs2=1 -> 1; SLTU same -> 0.
REQ-035 LOAD rs1=0x100, imm=4, rd=5, ack after 3 MEM cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x104 stable 3 cycles, in_ready=0, then out_data=0xDEADBEEF, out_rd=5.
REQ-036 BEQ rs1=rs2=7, pc=0x40, imm=-8 -> jmp_en=flush=1 one cycle, jmp_addr=0x38; BNE same operands -> jmp_en=0.
REQ-037 JAL pc=0x200, imm=0x10, rd=1 -> jmp_addr=0x210, out_data=0x204, out_we=1; rd=0 -> out_we=0.
REQ-038 STORE issued, rst low mid-MEM, ack after release -> mem_req=0 immediately, no out_valid, in_ready=1.
